// File: rtl/led_pattern_sequencer_pkg.sv
// Shared definitions for the LED pattern sequencer: MMIO address map,
// mode encodings and FSM state codes.
package led_pattern_sequencer_pkg;

  localparam int DATA_W_DEF = 16;

  localparam logic [1:0] ADDR_DIRECT  = 2'b00;
  localparam logic [1:0] ADDR_MODE    = 2'b01;
  localparam logic [1:0] ADDR_PERIOD  = 2'b10;
  localparam logic [1:0] ADDR_PATTERN = 2'b11;

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_BLINK  = 2'b01;
  localparam logic [1:0] MODE_SCROLL = 2'b10;

  typedef enum logic [1:0] {
    S_DIRECT    = 2'b00,
    S_BLINK_ON  = 2'b01,
    S_BLINK_OFF = 2'b10,
    S_SCROLL    = 2'b11
  } state_t;

endpackage

// File: rtl/led_pattern_sequencer_tick_gen.sv
// Pattern tick source: prescaler producing a base tick, then a period counter
// that fires once every (period+1) base ticks. clr restarts a full period.
module led_tick_gen #(
  parameter int PRESCALE = 100000,
  parameter int PS_W     = 17
) (
  input  logic        ledclk,
  input  logic        ledrst,
  input  logic        clr,
  input  logic [15:0] period,
  output logic        tick
);

  logic [PS_W-1:0] ps_cnt;
  logic [15:0]     per_cnt;
  logic            base_tick;
  logic            per_hit;

  assign base_tick = (ps_cnt == PS_W'(PRESCALE - 1));
  assign per_hit   = (per_cnt == period);
  assign tick      = base_tick && per_hit && !clr;

  always_ff @(posedge ledclk) begin
    if (ledrst || clr) begin
      ps_cnt  <= '0;
      per_cnt <= '0;
    end else if (base_tick) begin
      ps_cnt  <= '0;
      per_cnt <= per_hit ? 16'd0 : per_cnt + 16'd1;
    end else begin
      ps_cnt  <= ps_cnt + PS_W'(1);
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// CPU-facing LED driver front end: MMIO register file, direct/blink/scroll
// sequencing FSM and single-cycle registered write pulses to the driver.
//
//   state       | meaning
//   S_DIRECT    | CPU DIRECT writes forwarded, ticks ignored
//   S_BLINK_ON  | PATTERN shown, next tick blanks
//   S_BLINK_OFF | blank shown, next tick shows PATTERN
//   S_SCROLL    | shown rotated by one bit per tick
module led_pattern_sequencer
  import led_pattern_sequencer_pkg::*;
#(
  parameter int          DATA_W     = DATA_W_DEF,
  parameter int          PRESCALE   = 100000,
  parameter int          PS_W       = 17,
  parameter logic [15:0] DEF_PERIOD = 16'd250
) (
  input  logic              ledclk,
  input  logic              ledrst,
  input  logic              cpu_cs,
  input  logic              cpu_write,
  input  logic [1:0]        cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              drv_cs,
  output logic              drv_write,
  output logic [DATA_W-1:0] drv_data,
  output logic              busy
);

  logic [DATA_W-1:0] direct_q, pattern_q, shown_q, shown_d, pdata_d;
  logic [2:0]        mode_q;
  logic [15:0]       period_q;
  state_t            state_q, state_d;
  logic              wr, tick, tick_clr, pulse_d;
  logic [DATA_W-1:0] rot_l, rot_r;

  assign wr       = cpu_cs && cpu_write;
  assign tick_clr = wr && (cpu_addr != ADDR_DIRECT);
  assign rot_l    = {shown_q[DATA_W-2:0], shown_q[DATA_W-1]};
  assign rot_r    = {shown_q[0], shown_q[DATA_W-1:1]};
  assign busy     = (state_q != S_DIRECT);

  led_tick_gen #(.PRESCALE(PRESCALE), .PS_W(PS_W)) u_tick (
    .ledclk (ledclk),
    .ledrst (ledrst),
    .clr    (tick_clr),
    .period (period_q),
    .tick   (tick)
  );

  always_comb begin
    unique case (cpu_addr)
      ADDR_DIRECT:  cpu_rdata = direct_q;
      ADDR_MODE:    cpu_rdata = DATA_W'(mode_q);
      ADDR_PERIOD:  cpu_rdata = DATA_W'(period_q);
      ADDR_PATTERN: cpu_rdata = pattern_q;
    endcase
  end

  // Any CPU write takes the cycle; a coincident tick is simply lost.
  always_comb begin
    state_d = state_q;
    shown_d = shown_q;
    pulse_d = 1'b0;
    pdata_d = '0;
    if (wr) begin
      unique case (cpu_addr)
        ADDR_DIRECT: begin
          if (state_q == S_DIRECT) begin
            pulse_d = 1'b1;
            pdata_d = cpu_wdata;
          end
        end
        ADDR_MODE: begin
          pulse_d = 1'b1;
          case (cpu_wdata[1:0])
            MODE_BLINK: begin
              state_d = S_BLINK_ON;
              pdata_d = pattern_q;
            end
            MODE_SCROLL: begin
              state_d = S_SCROLL;
              shown_d = pattern_q;
              pdata_d = pattern_q;
            end
            default: begin
              state_d = S_DIRECT;
              pdata_d = direct_q;
            end
          endcase
        end
        ADDR_PERIOD: ;
        ADDR_PATTERN: begin
          if (state_q == S_BLINK_ON || state_q == S_BLINK_OFF) begin
            state_d = S_BLINK_ON;
            pulse_d = 1'b1;
            pdata_d = cpu_wdata;
          end else if (state_q == S_SCROLL) begin
            shown_d = cpu_wdata;
            pulse_d = 1'b1;
            pdata_d = cpu_wdata;
          end
        end
      endcase
    end else if (tick) begin
      unique case (state_q)
        S_DIRECT: ;
        S_BLINK_ON: begin
          state_d = S_BLINK_OFF;
          pulse_d = 1'b1;
          pdata_d = '0;
        end
        S_BLINK_OFF: begin
          state_d = S_BLINK_ON;
          pulse_d = 1'b1;
          pdata_d = pattern_q;
        end
        S_SCROLL: begin
          shown_d = mode_q[2] ? rot_r : rot_l;
          pulse_d = 1'b1;
          pdata_d = mode_q[2] ? rot_r : rot_l;
        end
      endcase
    end
  end

  always_ff @(posedge ledclk) begin
    if (ledrst) begin
      direct_q  <= '0;
      mode_q    <= '0;
      period_q  <= DEF_PERIOD;
      pattern_q <= DATA_W'(1);
      shown_q   <= '0;
      state_q   <= S_DIRECT;
      drv_cs    <= 1'b0;
      drv_write <= 1'b0;
      drv_data  <= '0;
    end else begin
      if (wr) begin
        unique case (cpu_addr)
          ADDR_DIRECT:  direct_q  <= cpu_wdata;
          ADDR_MODE:    mode_q    <= cpu_wdata[2:0];
          ADDR_PERIOD:  period_q  <= cpu_wdata[15:0];
          ADDR_PATTERN: pattern_q <= cpu_wdata;
        endcase
      end
      state_q   <= state_d;
      shown_q   <= shown_d;
      drv_cs    <= pulse_d;
      drv_write <= pulse_d;
      if (pulse_d) drv_data <= pdata_d;
    end
  end

endmodule
